// File: rtl/btn_debounce.sv
// Per-channel two-flop synchronizer followed by a debounce FSM. A level change reaches
// btn_out only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
module btn_debounce #(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_out,
    output logic [WIDTH-1:0] busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [1:0] {
        StLow      = 2'b00,
        StPendHigh = 2'b01,
        StHigh     = 2'b10,
        StPendLow  = 2'b11
    } state_e;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             out_q;
        logic             smp;

        assign smp = sync2_q[ch];

        // Any opposite sample drops back to the stable state and clears the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StLow;
                cnt_q   <= '0;
                out_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StLow: begin
                        if (smp) begin
                            state_q <= StPendHigh;
                            cnt_q   <= CntOne;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    StPendHigh: begin
                        if (!smp) begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StHigh;
                            out_q   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CntOne;
                        end
                    end
                    StHigh: begin
                        if (!smp) begin
                            state_q <= StPendLow;
                            cnt_q   <= CntOne;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    StPendLow: begin
                        if (smp) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StLow;
                            out_q   <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CntOne;
                        end
                    end
                    default: begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                        out_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_out[ch] = out_q;
        assign busy[ch]    = (state_q == StPendHigh) || (state_q == StPendLow);

`ifndef SYNTHESIS
        cnt_bound_a : assert property (@(posedge clk) disable iff (rst) cnt_q <= CntLast);
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: one DUT with DEBOUNCE_CYCLES=4 and one with the
// minimum value 2, both two channels wide.
module tb_btn_debounce;

    logic       clk;
    logic       rst;
    logic [1:0] btn_in;
    logic [1:0] btn_out;
    logic [1:0] busy;
    logic [1:0] btn_in2;
    logic [1:0] btn_out2;
    logic [1:0] busy2;

    int n_checks;
    int n_fail;

    btn_debounce #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in),
        .btn_out(btn_out),
        .busy   (busy)
    );

    btn_debounce #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(2)
    ) dut2 (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_in2),
        .btn_out(btn_out2),
        .busy   (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_in  = 2'b00;
        btn_in2 = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [1:0] eo;
        logic [1:0] eb;
        rst     = 1'b1;
        btn_in  = 2'b11;
        btn_in2 = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (btn_out !== 2'b00 || busy !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d out=%b busy=%b required out=00 busy=00",
                         k, btn_out, busy);
            end
            n_checks++;
        end
        rst = 1'b0;
        // Edge numbering: the first edge after release is edge 1.
        for (int k = 1; k <= 8; k++) begin
            tick();
            eo = (k >= 6) ? 2'b11 : 2'b00;
            eb = (k >= 3 && k <= 5) ? 2'b11 : 2'b00;
            if (btn_out !== eo || busy !== eb) begin
                n_fail++;
                $display("FAIL reset_release edge=%0d out=%b busy=%b required out=%b busy=%b",
                         k, btn_out, busy, eo, eb);
            end
            n_checks++;
        end
    endtask

    task automatic test_clean_press();
        logic [1:0] eo;
        logic [1:0] eb;
        do_reset();
        btn_in = 2'b01;
        for (int k = 0; k < 9; k++) begin
            tick();
            eo = (k >= 5) ? 2'b01 : 2'b00;
            eb = (k >= 2 && k <= 4) ? 2'b01 : 2'b00;
            if (btn_out !== eo || busy !== eb) begin
                n_fail++;
                $display("FAIL clean_press e%0d out=%b busy=%b required out=%b busy=%b",
                         k, btn_out, busy, eo, eb);
            end
            n_checks++;
        end
    endtask

    // Follows test_clean_press: channel 0 is debounced high.
    task automatic test_release_glitch();
        logic eb;
        btn_in[0] = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k == 3) btn_in[0] = 1'b1;
            tick();
            eb = (k >= 2 && k <= 4);
            if (btn_out[0] !== 1'b1 || busy[0] !== eb) begin
                n_fail++;
                $display("FAIL release_glitch a%0d out0=%b busy0=%b required out0=1 busy0=%b",
                         k, btn_out[0], busy[0], eb);
            end
            n_checks++;
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        logic       eo;
        pat = 8'b1111_0111; // bit k is the level applied before edge k
        do_reset();
        for (int k = 0; k < 13; k++) begin
            btn_in[0] = (k < 8) ? pat[k] : 1'b1;
            tick();
            eo = (k >= 9);
            if (btn_out[0] !== eo) begin
                n_fail++;
                $display("FAIL bounce e%0d out0=%b required %b", k, btn_out[0], eo);
            end
            n_checks++;
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] eo;
        logic [1:0] eb;
        do_reset();
        btn_in = 2'b11;
        for (int k = 0; k < 4; k++) tick();
        if (busy !== 2'b11 || btn_out !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_pre out=%b busy=%b required out=00 busy=11", btn_out, busy);
        end
        n_checks++;
        #2;
        rst = 1'b1;
        #1;
        if (busy !== 2'b00 || btn_out !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_async out=%b busy=%b required out=00 busy=00",
                     btn_out, busy);
        end
        n_checks++;
        tick();
        tick();
        if (busy !== 2'b00 || btn_out !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_held out=%b busy=%b required out=00 busy=00", btn_out, busy);
        end
        n_checks++;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            eo = (k >= 6) ? 2'b11 : 2'b00;
            eb = (k >= 3 && k <= 5) ? 2'b11 : 2'b00;
            if (btn_out !== eo || busy !== eb) begin
                n_fail++;
                $display("FAIL mid_reset_requal edge=%0d out=%b busy=%b required out=%b busy=%b",
                         k, btn_out, busy, eo, eb);
            end
            n_checks++;
        end
    endtask

    task automatic test_independence();
        logic [1:0] eo;
        logic [1:0] eb;
        do_reset();
        btn_in = 2'b01;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) btn_in[1] = 1'b1;
            tick();
            eo = {(k >= 7), (k >= 5)};
            eb = {(k >= 4 && k <= 6), (k >= 2 && k <= 4)};
            if (btn_out !== eo || busy !== eb) begin
                n_fail++;
                $display("FAIL independence e%0d out=%b busy=%b required out=%b busy=%b",
                         k, btn_out, busy, eo, eb);
            end
            n_checks++;
        end
    endtask

    task automatic test_min_cycles();
        logic [1:0] eo;
        logic [1:0] eb;
        do_reset();
        btn_in2 = 2'b11;
        for (int k = 0; k < 6; k++) begin
            tick();
            eo = (k >= 3) ? 2'b11 : 2'b00;
            eb = (k == 2) ? 2'b11 : 2'b00;
            if (btn_out2 !== eo || busy2 !== eb) begin
                n_fail++;
                $display("FAIL min_press e%0d out=%b busy=%b required out=%b busy=%b",
                         k, btn_out2, busy2, eo, eb);
            end
            n_checks++;
        end
        // Single-sample drop on channel 0 must be rejected.
        btn_in2 = 2'b10;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) btn_in2 = 2'b11;
            tick();
            eb = (k == 2) ? 2'b01 : 2'b00;
            if (btn_out2 !== 2'b11 || busy2 !== eb) begin
                n_fail++;
                $display("FAIL min_glitch a%0d out=%b busy=%b required out=11 busy=%b",
                         k, btn_out2, busy2, eb);
            end
            n_checks++;
        end
        btn_in2 = 2'b00;
        for (int k = 0; k < 6; k++) begin
            tick();
            eo = (k >= 3) ? 2'b00 : 2'b11;
            eb = (k == 2) ? 2'b11 : 2'b00;
            if (btn_out2 !== eo || busy2 !== eb) begin
                n_fail++;
                $display("FAIL min_release e%0d out=%b busy=%b required out=%b busy=%b",
                         k, btn_out2, busy2, eo, eb);
            end
            n_checks++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        btn_in   = 2'b00;
        btn_in2  = 2'b00;
        test_reset();
        test_clean_press();
        test_release_glitch();
        test_bounce();
        test_mid_reset();
        test_independence();
        test_min_cycles();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
